// File: rtl/shift_add_multiplier_64bit_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_add_multiplier_64bit_pkg;

    localparam int MUL_WIDTH = 64;
    localparam int MUL_ITERS = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/carry_lookahead_adder_64bit.sv
// 64-bit adder: 4-bit lookahead groups chained by group generate/propagate.
// Latency: purely combinational.
// Backpressure: none.
module carry_lookahead_adder_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] s,
    output logic        cout,
    output logic        grp_gen,
    output logic        grp_prop
);

    logic [63:0] gb;
    logic [63:0] pb;
    logic [64:0] c;
    logic [15:0] blk_g;
    logic [15:0] blk_p;
    logic        g_acc;

    // Bit and group lookahead terms, then carries rippled group-to-group.
    always_comb begin
        gb    = a & b;
        pb    = a ^ b;
        c     = '0;
        blk_g = '0;
        blk_p = '0;
        g_acc = 1'b0;
        c[0]  = cin;
        for (int k = 0; k < 16; k++) begin
            c[4*k+1] = gb[4*k] | (pb[4*k] & c[4*k]);
            c[4*k+2] = gb[4*k+1] | (pb[4*k+1] & gb[4*k])
                     | (pb[4*k+1] & pb[4*k] & c[4*k]);
            c[4*k+3] = gb[4*k+2] | (pb[4*k+2] & gb[4*k+1])
                     | (pb[4*k+2] & pb[4*k+1] & gb[4*k])
                     | (pb[4*k+2] & pb[4*k+1] & pb[4*k] & c[4*k]);
            blk_g[k] = gb[4*k+3] | (pb[4*k+3] & gb[4*k+2])
                     | (pb[4*k+3] & pb[4*k+2] & gb[4*k+1])
                     | (pb[4*k+3] & pb[4*k+2] & pb[4*k+1] & gb[4*k]);
            blk_p[k] = &pb[4*k +: 4];
            c[4*k+4] = blk_g[k] | (blk_p[k] & c[4*k]);
            g_acc    = blk_g[k] | (blk_p[k] & g_acc);
        end
    end

    assign s        = pb ^ c[63:0];
    assign cout     = c[64];
    assign grp_gen  = g_acc;
    assign grp_prop = &blk_p;

endmodule

// File: rtl/shift_add_multiplier_64bit.sv
// Radix-2 unsigned 64x64->128 multiplier, one conditional add-and-shift per clock.
// Latency: 64 iterations; done pulses in the cycle after the 64th edge following start.
// Backpressure: start is only accepted in IDLE or DONE; ignored while busy.
module shift_add_multiplier_64bit
    import shift_add_multiplier_64bit_pkg::*;
#(
    parameter int WIDTH      = MUL_WIDTH,
    parameter int COUNT_BITS = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 hi_nonzero
);

    mul_state_t              state;
    mul_state_t              state_next;
    logic [COUNT_BITS-1:0]   count;
    logic [WIDTH-1:0]        mcand;
    logic [2*WIDTH-1:0]      prod_next;
    logic [WIDTH-1:0]        add_b;
    logic [WIDTH-1:0]        add_s;
    logic                    add_cout;
    logic                    unused_gen;
    logic                    unused_prop;
    logic                    load;
    logic                    iterate;
    logic                    last_iter;

    // Upper half of the partial product plus mcand when the current multiplier bit is set.
    assign add_b     = product[0] ? mcand : '0;
    // Carry-out lands in bit 127 so the running product never loses a bit.
    assign prod_next = {add_cout, add_s, product[WIDTH-1:1]};
    assign last_iter = (count == COUNT_BITS'(MUL_ITERS - 1));

    carry_lookahead_adder_64bit u_adder (
        .a        (product[2*WIDTH-1:WIDTH]),
        .b        (add_b),
        .cin      (1'b0),
        .s        (add_s),
        .cout     (add_cout),
        .grp_gen  (unused_gen),
        .grp_prop (unused_prop)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and handshake decode; DONE accepts a new start for back-to-back use.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        iterate    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                iterate = 1'b1;
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, shift-add iteration and overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            count      <= '0;
            mcand      <= '0;
            product    <= '0;
            hi_nonzero <= 1'b0;
        end else if (load) begin
            count      <= '0;
            mcand      <= a;
            product    <= {{WIDTH{1'b0}}, b};
            hi_nonzero <= 1'b0;
        end else if (iterate) begin
            product <= prod_next;
            count   <= count + COUNT_BITS'(1);
            if (last_iter) hi_nonzero <= |prod_next[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier_64bit.sv
// Directed and randomized checks of the shift-add multiplier against hand-computed products.
// Latency: checks 64 busy cycles and a single done pulse per accepted start.
// Backpressure: exercises start while busy and start during the DONE cycle.
module tb_shift_add_multiplier_64bit;

    logic         clock;
    logic         reset;
    logic         start;
    logic [63:0]  a;
    logic [63:0]  b;
    logic         busy;
    logic         done;
    logic [127:0] product;
    logic         hi_nonzero;

    int n_checks;
    int n_fail;

    shift_add_multiplier_64bit dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .hi_nonzero (hi_nonzero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse; it is dropped again by the first negedge inside wait_done.
    task automatic launch(input logic [63:0] av, input logic [63:0] bv);
        @(negedge clock);
        a     = av;
        b     = bv;
        start = 1'b1;
    endtask

    // Count busy cycles until done; optionally inject a start while busy.
    task automatic wait_done(input int inject_at, input logic [63:0] ia, input logic [63:0] ib,
                             output int nbusy, output bit seen);
        nbusy = 0;
        seen  = 1'b0;
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) nbusy++;
                if (busy && nbusy == inject_at) begin
                    start = 1'b1;
                    a     = ia;
                    b     = ib;
                end
            end
        end
    endtask

    task automatic run_and_check(input string tag, input logic [63:0] av, input logic [63:0] bv,
                                 input logic [127:0] exp_p, input logic exp_hi);
        int nb;
        bit sd;
        launch(av, bv);
        wait_done(-1, '0, '0, nb, sd);
        chk({tag, "_busy_cycles"}, 128'(nb), 128'd64);
        chk({tag, "_done"}, 128'(sd), 128'd1);
        chk({tag, "_product"}, product, exp_p);
        chk({tag, "_hi"}, 128'(hi_nonzero), 128'(exp_hi));
        @(negedge clock);
        chk({tag, "_done_one_cycle"}, 128'(done), 128'd0);
        chk({tag, "_product_hold"}, product, exp_p);
    endtask

    initial begin
        int          nb;
        bit          sd;
        int          ndone;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [127:0] ref_p;

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) @(negedge clock);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_done", 128'(done), 128'd0);
        chk("reset_product", product, 128'd0);
        chk("reset_hi", 128'(hi_nonzero), 128'd0);
        reset = 1'b0;

        run_and_check("3x5", 64'd3, 64'd5, 128'd15, 1'b0);
        run_and_check("max_sq", 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                      128'hFFFFFFFFFFFFFFFE0000000000000001, 1'b1);

        // hi_nonzero from the previous run must clear on the accepted start.
        launch(64'h8000000000000000, 64'd2);
        @(negedge clock);
        start = 1'b0;
        chk("hi_clear_on_start", 128'(hi_nonzero), 128'd0);
        chk("busy_after_start", 128'(busy), 128'd1);
        wait_done(-1, '0, '0, nb, sd);
        chk("msb_x2_busy_cycles", 128'(nb), 128'd63);
        chk("msb_x2_done", 128'(sd), 128'd1);
        chk("msb_x2_product", product, 128'h00000000000000010000000000000000);
        chk("msb_x2_hi", 128'(hi_nonzero), 128'd1);

        run_and_check("zero_a", 64'd0, 64'h1234, 128'd0, 1'b0);

        // Start during RUN is ignored; start in DONE is accepted back-to-back.
        launch(64'd7, 64'd6);
        wait_done(10, 64'd9, 64'd9, nb, sd);
        chk("ignore_busy_cycles", 128'(nb), 128'd64);
        chk("ignore_done", 128'(sd), 128'd1);
        chk("ignore_product", product, 128'd42);
        a     = 64'd2;
        b     = 64'd3;
        start = 1'b1;
        wait_done(-1, '0, '0, nb, sd);
        chk("b2b_busy_cycles", 128'(nb), 128'd64);
        chk("b2b_done", 128'(sd), 128'd1);
        chk("b2b_product", product, 128'd6);

        // Reset mid-run abandons the operation without a done pulse.
        @(negedge clock);
        launch(64'd5, 64'd5);
        @(negedge clock);
        start = 1'b0;
        repeat (29) @(negedge clock);
        chk("pre_reset_busy", 128'(busy), 128'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_done", 128'(done), 128'd0);
        chk("midrst_product", product, 128'd0);
        chk("midrst_hi", 128'(hi_nonzero), 128'd0);
        ndone = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (done || busy) ndone++;
        end
        chk("midrst_no_done", 128'(ndone), 128'd0);
        run_and_check("11x13", 64'd11, 64'd13, 128'd143, 1'b0);

        // Randomized operands against a native 128-bit multiply.
        for (int i = 0; i < 300; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 4 == 1) ra = ra >> $urandom_range(63, 0);
            if (i % 4 == 2) rb = rb >> $urandom_range(63, 0);
            ref_p = {64'd0, ra} * {64'd0, rb};
            launch(ra, rb);
            wait_done(-1, '0, '0, nb, sd);
            chk("rand_done", 128'(sd), 128'd1);
            chk("rand_product", product, ref_p);
            chk("rand_hi", 128'(hi_nonzero), 128'(|ref_p[127:64]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
